fp_mul_pipe: RTL and testbench
==============================

Name: fp_mul_pipe

Overview:
Parametrised, 3-stage pipelined IEEE-754-style floating-point multiplier with a valid/ready stream interface.
- Generalises the single-cycle FP32 multiplier: exponent/mantissa widths are parameters; rounding is round-to-nearest-even.
- Handles zero, infinity and NaN; flushes subnormals to zero; reports exception flags.
- Sits in the arithmetic datapath between operand staging and the result writeback stream.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored fraction width (hidden bit implicit)
W, EXP_W+MAN_W+1, total operand width (derived; not overridable)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands this cycle
in_a  input  W  operand A {sign, exp, frac}
in_b  input  W  operand B
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_p  output  W  product
out_flags  output  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Reset: clk and a single asynchronous, active-low reset rst_n. On assertion, all stage valid bits clear, out_valid=0, out_p=0, out_flags=0; in_ready=1 once reset releases. Reset mid-operation discards in-flight data; no result is emitted for it.
- Handshake:
  - Global advance enable adv = !out_valid | out_ready; in_ready = adv (combinational).
  - Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
  - When adv=0, all stages hold, including out_p and out_flags, which stay stable while out_valid=1.
  - Bubbles propagate as valid=0 and do not prevent acceptance.
- Latency: exactly 3 clk from accepted input to out_valid with out_ready held high. Throughput 1 per clk.
- Stage 1 (unpack):
  - sign = a.s ^ b.s.
  - Classify each operand as zero (exp==0, any fraction; subnormal flushed to zero), inf (exp all-ones, frac==0) or NaN (exp all-ones, frac!=0).
  - Exponent sum e = ea + eb - bias, computed signed at EXP_W+2 bits.
  - Mantissa product m = {1,fa}*{1,fb}, 2*MAN_W+2 bits.
- Stage 2 (normalise/round):
  - If m MSB is set: e += 1 and take the upper MAN_W+1 bits; otherwise shift left by 1.
  - guard = next bit; round = following bit; sticky = OR of the rest.
  - RNE: increment when guard & (round | sticky | lsb).
  - Mantissa carry-out after rounding: shift right 1 and e += 1.
  - inexact = guard | round | sticky.
- Stage 3 (pack/except), priority order:
  1. Any NaN input, or inf*zero: out_p = quiet NaN {0, all-ones exp, 1 then zeros}; invalid=1 only for inf*zero or when a NaN input has frac MSB=0 (signalling).
  2. Any inf input: signed infinity, no flags.
  3. Any zero input: signed zero, no flags.
  4. e >= 2^EXP_W-1: signed infinity, overflow=1, inexact=1.
  5. e <= 0: signed zero (FTZ), underflow=1, inexact=1.
  6. Otherwise pack {sign, e[EXP_W-1:0], mant[MAN_W-1:0]} with stage-2 inexact.
- Flags are per-result; nothing is sticky across results.

Decomposition:
- Shared package fp_pkg: FP class enum (ZERO, NORM, INF, NAN), flag bit index constants (FLG_INV=3, FLG_OVF=2, FLG_UDF=1, FLG_INX=0), and a bias/qNaN constant function of EXP_W/MAN_W.
- One natural sub-module: fp_round_rne (normalise plus RNE on the raw product; outputs mantissa, exponent increment 0..2 and inexact), instantiated in stage 2.

Test Plan:
- 0x3FC00000 * 0x40000000 (1.5*2.0) -> 0x40400000, flags 0, out_valid exactly 3 clk after acceptance.
- 0x3F800001 * 0x3FC00000 (exact tie, lsb=1) -> 0x3FC00002, inexact=1; 0x3F800001 * 0x3F800001 -> 0x3F800002, inexact=1.
- 0x7F800000 * 0x00000000 -> 0x7FC00000, invalid=1; 0xFF800000 * 0x40000000 -> 0xFF800000, flags 0.
- Overflow/underflow: 0x7F000000 * 0x7F000000 -> 0x7F800000, flags 0b0101; 0x00800000 * 0x3F000000 -> 0x00000000, flags 0b0011.
- Back-to-back stream of 8 operand pairs with out_ready low for cycles 4-7 -> in_ready low while stalled, out_p stable, all 8 results in order, none lost or duplicated.
- rst_n asserted with 3 results in flight -> out_valid=0 immediately; after release, first new input yields out_valid 3 clk later with the correct value.

Source files
------------

// File: rtl/fp_pkg.sv
// Purpose: shared types and constants for the pipelined FP multiplier.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package fp_pkg;

  // Operand classification after subnormal flush-to-zero.
  typedef enum logic [1:0] {
    FP_ZERO = 2'd0,
    FP_NORM = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_e;

  // Bit positions within the 4-bit exception flag vector.
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UDF = 1;
  localparam int FLG_INX = 0;

  // Constant-function results are returned wide and sliced by the user.
  localparam int FP_CONST_W = 128;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [FP_CONST_W-1:0] fp_qnan(input int exp_w, input int man_w);
    logic [FP_CONST_W-1:0] r;
    r = ((FP_CONST_W'(1) << exp_w) - FP_CONST_W'(1)) << man_w;
    r = r | (FP_CONST_W'(1) << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_round.sv
// Purpose: normalise a raw significand product and round it to nearest-even.
// Latency: combinational (sits inside stage 2 of fp_mul_pipe).
// Backpressure: none; the enclosing stage register does the holding.
// Ports: man_i raw {1,fa}*{1,fb} product; mant_o rounded fraction (hidden
//        bit dropped); exp_inc_o exponent increment 0..2; inexact_o any
//        discarded bit was set.
module fp_round_rne #(
  parameter int MAN_W = 23
) (
  input  logic [2*MAN_W+1:0] man_i,
  output logic [MAN_W-1:0]   mant_o,
  output logic [1:0]         exp_inc_o,
  output logic               inexact_o
);

  localparam int PW = 2*MAN_W + 2;

  logic [PW-1:0]    norm;
  logic [MAN_W:0]   hi;
  logic             guard;
  logic             rnd;
  logic             sticky;
  logic             rne;
  logic [MAN_W+1:0] sum;
  logic             carry;

  always_comb begin
    // Product of two [1,2) significands lies in [1,4): at most one shift.
    norm   = man_i[PW-1] ? man_i : {man_i[PW-2:0], 1'b0};
    hi     = norm[PW-1 -: MAN_W+1];
    guard  = norm[MAN_W];
    rnd    = norm[MAN_W-1];
    sticky = |norm[MAN_W-2:0];
    rne    = guard & (rnd | sticky | hi[0]);
    sum    = {1'b0, hi} + {{(MAN_W+1){1'b0}}, rne};
    carry  = sum[MAN_W+1];
    // On carry-out the significand is exactly 10..0, so the shifted-out bit is 0.
    mant_o    = carry ? sum[MAN_W:1] : sum[MAN_W-1:0];
    exp_inc_o = {1'b0, man_i[PW-1]} + {1'b0, carry};
    inexact_o = guard | rnd | sticky;
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Purpose: 3-stage pipelined IEEE-754-style multiplier (RNE, FTZ, flags).
// Latency: 3 clk from accepted operands to out_valid; 1 result per clk.
// Backpressure: all stages stall together while out_valid & !out_ready.
// Ports: in_valid/in_ready/in_a/in_b operand stream; out_valid/out_ready/
//        out_p/out_flags result stream, flags {invalid,overflow,underflow,inexact}.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_p,
  output logic [3:0]   out_flags
);

  localparam int EW = EXP_W + 2;
  localparam int PW = 2*MAN_W + 2;
  localparam logic signed [EW-1:0] BIAS_S = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);
  localparam logic [FP_CONST_W-1:0] QNAN_WIDE = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0] QNAN = QNAN_WIDE[W-1:0];

  logic adv;

  // ---------------- Stage 1: unpack ----------------
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  fp_class_e        cls_a_d, cls_b_d;
  logic             snan_d;
  logic signed [EW-1:0] s1_exp_d;
  logic [PW-1:0]    s1_man_d;

  logic                 s1_vld_q;
  logic                 s1_sign_q;
  fp_class_e            s1_cls_a_q, s1_cls_b_q;
  logic                 s1_snan_q;
  logic signed [EW-1:0] s1_exp_q;
  logic [PW-1:0]        s1_man_q;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign ea = in_a[W-2:MAN_W];
  assign eb = in_b[W-2:MAN_W];
  assign fa = in_a[MAN_W-1:0];
  assign fb = in_b[MAN_W-1:0];

  always_comb begin
    cls_a_d = FP_NORM;
    cls_b_d = FP_NORM;
    // Exponent 0 covers true zero and subnormals (flushed to zero).
    if (ea == '0)      cls_a_d = FP_ZERO;
    else if (ea == '1) cls_a_d = (fa == '0) ? FP_INF : FP_NAN;
    if (eb == '0)      cls_b_d = FP_ZERO;
    else if (eb == '1) cls_b_d = (fb == '0) ? FP_INF : FP_NAN;
    // Signalling NaN: quiet bit (fraction MSB) clear.
    snan_d   = ((cls_a_d == FP_NAN) && !fa[MAN_W-1]) ||
               ((cls_b_d == FP_NAN) && !fb[MAN_W-1]);
    s1_exp_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
    s1_man_d = {{(MAN_W+1){1'b0}}, 1'b1, fa} * {{(MAN_W+1){1'b0}}, 1'b1, fb};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_cls_a_q <= FP_ZERO;
      s1_cls_b_q <= FP_ZERO;
      s1_snan_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_man_q   <= '0;
    end else if (adv) begin
      s1_vld_q   <= in_valid;
      s1_sign_q  <= in_a[W-1] ^ in_b[W-1];
      s1_cls_a_q <= cls_a_d;
      s1_cls_b_q <= cls_b_d;
      s1_snan_q  <= snan_d;
      s1_exp_q   <= s1_exp_d;
      s1_man_q   <= s1_man_d;
    end
  end

  // ---------------- Stage 2: normalise / round ----------------
  logic [MAN_W-1:0] r_frac;
  logic [1:0]       r_inc;
  logic             r_inx;

  logic                 s2_vld_q;
  logic                 s2_sign_q;
  fp_class_e            s2_cls_a_q, s2_cls_b_q;
  logic                 s2_snan_q;
  logic signed [EW-1:0] s2_exp_q;
  logic [MAN_W-1:0]     s2_frac_q;
  logic                 s2_inx_q;

  fp_round_rne #(.MAN_W(MAN_W)) u_round (
    .man_i     (s1_man_q),
    .mant_o    (r_frac),
    .exp_inc_o (r_inc),
    .inexact_o (r_inx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q   <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_cls_a_q <= FP_ZERO;
      s2_cls_b_q <= FP_ZERO;
      s2_snan_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_frac_q  <= '0;
      s2_inx_q   <= 1'b0;
    end else if (adv) begin
      s2_vld_q   <= s1_vld_q;
      s2_sign_q  <= s1_sign_q;
      s2_cls_a_q <= s1_cls_a_q;
      s2_cls_b_q <= s1_cls_b_q;
      s2_snan_q  <= s1_snan_q;
      s2_exp_q   <= s1_exp_q + $signed({{EXP_W{1'b0}}, r_inc});
      s2_frac_q  <= r_frac;
      s2_inx_q   <= r_inx;
    end
  end

  // ---------------- Stage 3: pack / exceptions ----------------
  logic         any_nan, any_inf, any_zero, inf_zero, exp_low;
  logic [W-1:0] out_p_d;
  logic [3:0]   out_flags_d;
  logic         out_vld_q;
  logic [W-1:0] out_p_q;
  logic [3:0]   out_flags_q;

  assign any_nan  = (s2_cls_a_q == FP_NAN)  || (s2_cls_b_q == FP_NAN);
  assign any_inf  = (s2_cls_a_q == FP_INF)  || (s2_cls_b_q == FP_INF);
  assign any_zero = (s2_cls_a_q == FP_ZERO) || (s2_cls_b_q == FP_ZERO);
  // Each operand has one class, so inf and zero together means inf*zero.
  assign inf_zero = any_inf && any_zero;
  // e <= 0 tested structurally to stay clear of signed/unsigned mixing.
  assign exp_low  = s2_exp_q[EW-1] || (s2_exp_q == '0);

  always_comb begin
    out_p_d     = '0;
    out_flags_d = '0;
    if (any_nan || inf_zero) begin
      out_p_d              = QNAN;
      out_flags_d[FLG_INV] = inf_zero || s2_snan_q;
    end else if (any_inf) begin
      out_p_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (any_zero) begin
      out_p_d = {s2_sign_q, {(W-1){1'b0}}};
    end else if (s2_exp_q >= EMAX_S) begin
      out_p_d              = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      out_flags_d[FLG_OVF] = 1'b1;
      out_flags_d[FLG_INX] = 1'b1;
    end else if (exp_low) begin
      out_p_d              = {s2_sign_q, {(W-1){1'b0}}};
      out_flags_d[FLG_UDF] = 1'b1;
      out_flags_d[FLG_INX] = 1'b1;
    end else begin
      out_p_d              = {s2_sign_q, s2_exp_q[EXP_W-1:0], s2_frac_q};
      out_flags_d[FLG_INX] = s2_inx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q   <= 1'b0;
      out_p_q     <= '0;
      out_flags_q <= '0;
    end else if (adv) begin
      out_vld_q   <= s2_vld_q;
      out_p_q     <= out_p_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_p     = out_p_q;
  assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Purpose: scoreboard bench for fp_mul_pipe with directed FP32 vectors.
// Latency: checks 3-clk acceptance-to-result latency while out_ready is high.
// Backpressure: exercises a 4-cycle output stall and a mid-flight reset.
module tb_fp_mul_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_p;
  logic [3:0]  out_flags;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_flags (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] p;
    logic [3:0]  f;
    logic        lat;
    logic [31:0] cyc;
  } exp_t;

  localparam int NV = 13;
  logic [31:0] va [NV];
  logic [31:0] vb [NV];
  logic [31:0] vp [NV];
  logic [3:0]  vf [NV];

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  int          n_pop = 0;
  logic [31:0] cyc   = 0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_p     = '0;
  logic [3:0]  prev_f     = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input int i, input logic lat);
    exp_t e;
    e.p   = vp[i];
    e.f   = vf[i];
    e.lat = lat;
    e.cyc = cyc;
    sb_q.push_back(e);
  endtask

  task automatic send(input int i, input logic lat);
    int g;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_a     = va[i];
    in_b     = vb[i];
    #1;
    g = 0;
    while (!in_ready && g < 20) begin
      @(posedge clk); #2;
      g++;
    end
    if (in_ready) push(i, lat);
    else begin
      total++; bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 for vector %0d", i);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 40) begin
      @(posedge clk);
      g++;
    end
    chk("drain_pending", sb_q.size(), 0);
    repeat (4) @(posedge clk);
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks stalls.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_p", out_p, prev_p);
        chk("stall_flags", {28'b0, out_flags}, {28'b0, prev_f});
      end
      if (out_valid && !out_ready) chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        n_pop++;
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: got %0h expected no output", out_p);
        end else begin
          e = sb_q.pop_front();
          chk("product", out_p, e.p);
          chk("flags", {28'b0, out_flags}, {28'b0, e.f});
          if (e.lat) chk("latency", cyc - e.cyc, 32'd3);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_p     = out_p;
      prev_f     = out_flags;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int vi;
    int k;
    int snap;

    // a, b, expected product, expected flags {inv,ovf,udf,inx}
    va[0]  = 32'h3FC00000; vb[0]  = 32'h40000000; vp[0]  = 32'h40400000; vf[0]  = 4'b0000;
    va[1]  = 32'h3F800001; vb[1]  = 32'h3FC00000; vp[1]  = 32'h3FC00002; vf[1]  = 4'b0001;
    va[2]  = 32'h3F800001; vb[2]  = 32'h3F800001; vp[2]  = 32'h3F800002; vf[2]  = 4'b0001;
    va[3]  = 32'h7F800000; vb[3]  = 32'h00000000; vp[3]  = 32'h7FC00000; vf[3]  = 4'b1000;
    va[4]  = 32'hFF800000; vb[4]  = 32'h40000000; vp[4]  = 32'hFF800000; vf[4]  = 4'b0000;
    va[5]  = 32'h7F000000; vb[5]  = 32'h7F000000; vp[5]  = 32'h7F800000; vf[5]  = 4'b0101;
    va[6]  = 32'h00800000; vb[6]  = 32'h3F000000; vp[6]  = 32'h00000000; vf[6]  = 4'b0011;
    va[7]  = 32'h40400000; vb[7]  = 32'h40400000; vp[7]  = 32'h41100000; vf[7]  = 4'b0000;
    va[8]  = 32'hC0000000; vb[8]  = 32'h3FC00000; vp[8]  = 32'hC0400000; vf[8]  = 4'b0000;
    va[9]  = 32'h7F800001; vb[9]  = 32'h3F800000; vp[9]  = 32'h7FC00000; vf[9]  = 4'b1000;
    va[10] = 32'h7FC00000; vb[10] = 32'h00000000; vp[10] = 32'h7FC00000; vf[10] = 4'b0000;
    va[11] = 32'h80000000; vb[11] = 32'h3F800000; vp[11] = 32'h80000000; vf[11] = 4'b0000;
    va[12] = 32'h00000001; vb[12] = 32'h3F800000; vp[12] = 32'h00000000; vf[12] = 4'b0000;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_p", out_p, 32'd0);
    chk("rst_out_flags", {28'b0, out_flags}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Directed vectors, back-to-back with out_ready high
    for (int i = 0; i < NV; i++) send(i, 1'b1);
    idle();
    drain();

    // 8-deep stream with out_ready low for cycles 4-7
    snap = n_pop;
    vi = 0;
    k  = 0;
    while ((vi < 8 || k < 9) && k < 60) begin
      @(posedge clk); #1;
      out_ready = !(k >= 4 && k <= 7);
      if (vi < 8) begin
        in_valid = 1'b1;
        in_a     = va[vi];
        in_b     = vb[vi];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) begin
        push(vi, 1'b0);
        vi++;
      end
      k++;
    end
    chk("stream_accepted", vi, 8);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("stream_count", n_pop - snap, 8);

    // Reset with three results in flight
    send(0, 1'b0);
    send(1, 1'b0);
    send(7, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("inflight_valid", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_out_p", out_p, 32'd0);
    chk("midrst_out_flags", {28'b0, out_flags}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    snap = n_pop;
    send(8, 1'b1);
    idle();
    drain();
    chk("post_reset_count", n_pop - snap, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
